// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with wrap/saturate, parallel load, clock-enable
// prescaler and a registered one-cycle terminal-count pulse.
module counter_updown_mod #(
    parameter int unsigned NBITS_COUNTER = 8,
    parameter int unsigned MAX_VALUE     = 2**NBITS_COUNTER - 1,
    parameter int unsigned PRESCALE      = 1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Enable,
    input  logic                     Up,
    input  logic                     Saturate,
    input  logic                     Load,
    input  logic [NBITS_COUNTER-1:0] LoadValue,
    output logic [NBITS_COUNTER-1:0] Output,
    output logic                     Terminal
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [NBITS_COUNTER-1:0] MAXV    = NBITS_COUNTER'(MAX_VALUE);
    localparam logic [PW-1:0]            PS_LAST = PW'(PRESCALE - 1);

    logic [NBITS_COUNTER-1:0] count_q, count_d;
    logic [PW-1:0]            pre_q,   pre_d;
    logic                     term_q,  term_d;

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        term_d  = 1'b0;
        if (Load) begin
            count_d = (LoadValue > MAXV) ? MAXV : LoadValue;
            pre_d   = '0;
        end else if (Enable) begin
            if (pre_q == PS_LAST) begin
                pre_d = '0;
                // Step: the boundary is checked on the pre-step value.
                if (Up) begin
                    if (count_q == MAXV) begin
                        term_d  = 1'b1;
                        count_d = Saturate ? MAXV : '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    if (count_q == '0) begin
                        term_d  = 1'b1;
                        count_d = Saturate ? '0 : MAXV;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
            pre_q   <= '0;
            term_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            term_q  <= term_d;
        end
    end

    assign Output   = count_q;
    assign Terminal = term_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench: three counter configurations driven in parallel and
// compared every cycle against an arithmetic reference model.
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       rst, en, up, sat, ld;
    logic [3:0] lv;
    logic [3:0] dq [3];
    logic       dt [3];

    int unsigned MAXV [3] = '{9, 9, 15};
    int unsigned PSV  [3] = '{1, 3, 2};
    int unsigned m_c  [3];
    int unsigned m_p  [3];
    bit          m_t  [3];

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    counter_updown_mod #(.NBITS_COUNTER(4), .MAX_VALUE(9), .PRESCALE(1)) dut0 (
        .Clock(clk), .Reset(rst), .Enable(en), .Up(up), .Saturate(sat),
        .Load(ld), .LoadValue(lv), .Output(dq[0]), .Terminal(dt[0]));
    counter_updown_mod #(.NBITS_COUNTER(4), .MAX_VALUE(9), .PRESCALE(3)) dut1 (
        .Clock(clk), .Reset(rst), .Enable(en), .Up(up), .Saturate(sat),
        .Load(ld), .LoadValue(lv), .Output(dq[1]), .Terminal(dt[1]));
    counter_updown_mod #(.NBITS_COUNTER(4), .MAX_VALUE(15), .PRESCALE(2)) dut2 (
        .Clock(clk), .Reset(rst), .Enable(en), .Up(up), .Saturate(sat),
        .Load(ld), .LoadValue(lv), .Output(dq[2]), .Terminal(dt[2]));

    // Advance one edge, update the model from the inputs seen at that edge,
    // and return at the following falling edge for sampling/driving.
    task automatic cyc();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_c[k] = 0; m_p[k] = 0; m_t[k] = 0;
            end else if (ld) begin
                m_c[k] = (lv > MAXV[k]) ? MAXV[k] : lv;
                m_p[k] = 0; m_t[k] = 0;
            end else if (en) begin
                if (m_p[k] + 1 < PSV[k]) begin
                    m_p[k] = m_p[k] + 1; m_t[k] = 0;
                end else begin
                    m_p[k] = 0;
                    m_t[k] = up ? (m_c[k] == MAXV[k]) : (m_c[k] == 0);
                    if (up)
                        m_c[k] = sat ? ((m_c[k] < MAXV[k]) ? m_c[k] + 1 : MAXV[k])
                                     : (m_c[k] + 1) % (MAXV[k] + 1);
                    else
                        m_c[k] = sat ? ((m_c[k] > 0) ? m_c[k] - 1 : 0)
                                     : (m_c[k] + MAXV[k]) % (MAXV[k] + 1);
                end
            end else begin
                m_t[k] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; en = 0; up = 1; sat = 0; ld = 0; lv = 0;
        cyc(); cyc();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (dq[k] !== 4'd0 || dt[k] !== 1'b0)
                $display("FAIL reset[%0d] got out=%0d term=%0b expected out=0 term=0", k, dq[k], dt[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap_up();
        rst = 0; en = 1; up = 1; sat = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            total++;
            if (dq[0] !== 4'((i + 1) % 10) || dt[0] !== (i == 9))
                $display("FAIL wrap_up cycle %0d got out=%0d term=%0b expected out=%0d term=%0b",
                         i, dq[0], dt[0], (i + 1) % 10, (i == 9));
            else pass_cnt++;
        end
    endtask

    task automatic test_down();
        rst = 1; cyc(); rst = 0; en = 1; up = 0; sat = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (dq[0] !== 4'(9 - i) || dt[0] !== (i == 0))
                $display("FAIL down_wrap cycle %0d got out=%0d term=%0b expected out=%0d term=%0b",
                         i, dq[0], dt[0], 9 - i, (i == 0));
            else pass_cnt++;
        end
        rst = 1; cyc(); rst = 0; sat = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (dq[0] !== 4'd0 || dt[0] !== 1'b1)
                $display("FAIL down_sat cycle %0d got out=%0d term=%0b expected out=0 term=1",
                         i, dq[0], dt[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_clamp();
        sat = 1; up = 1; en = 1; ld = 1; lv = 4'd15;
        cyc();
        total++;
        if (dq[0] !== 4'd9 || dt[0] !== 1'b0 || dq[2] !== 4'd15)
            $display("FAIL load_clamp got out0=%0d term0=%0b out2=%0d expected 9 0 15", dq[0], dt[0], dq[2]);
        else pass_cnt++;
        ld = 0;
        cyc();
        total++;
        if (dq[0] !== 4'd9 || dt[0] !== 1'b1)
            $display("FAIL sat_hold got out=%0d term=%0b expected out=9 term=1", dq[0], dt[0]);
        else pass_cnt++;
    endtask

    task automatic test_prescale();
        logic [3:0] exp_o [5] = '{0, 0, 0, 0, 1};
        logic       exp_e [5] = '{1, 0, 0, 1, 1};
        rst = 1; cyc(); rst = 0; up = 1; sat = 0;
        for (int i = 0; i < 5; i++) begin
            en = exp_e[i];
            cyc();
            total++;
            if (dq[1] !== exp_o[i] || dt[1] !== 1'b0)
                $display("FAIL prescale cycle %0d got out=%0d term=%0b expected out=%0d term=0",
                         i, dq[1], dt[1], exp_o[i]);
            else pass_cnt++;
        end
        cyc(); cyc();
        total++;
        if (dq[1] !== 4'd1) $display("FAIL prescale_no_early got out=%0d expected 1", dq[1]);
        else pass_cnt++;
        cyc();
        total++;
        if (dq[1] !== 4'd2) $display("FAIL prescale_second got out=%0d expected 2", dq[1]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        ld = 1; lv = 4'd6; en = 0; cyc();
        ld = 0; en = 1; up = 1; sat = 0; cyc();
        total++;
        if (dq[1] !== 4'd6) $display("FAIL reset_mid_setup got out=%0d expected 6", dq[1]);
        else pass_cnt++;
        rst = 1; cyc(); rst = 0;
        total++;
        if (dq[1] !== 4'd0 || dt[1] !== 1'b0)
            $display("FAIL reset_mid got out=%0d term=%0b expected out=0 term=0", dq[1], dt[1]);
        else pass_cnt++;
        cyc(); cyc();
        total++;
        if (dq[1] !== 4'd0) $display("FAIL reset_mid_prescale got out=%0d expected 0", dq[1]);
        else pass_cnt++;
        cyc();
        total++;
        if (dq[1] !== 4'd1) $display("FAIL reset_mid_step got out=%0d expected 1", dq[1]);
        else pass_cnt++;
    endtask

    task automatic test_load_vs_step();
        en = 0; ld = 1; lv = 4'd9; cyc();
        en = 1; up = 1; sat = 0; ld = 1; lv = 4'd4; cyc();
        ld = 0;
        total++;
        if (dq[0] !== 4'd4 || dt[0] !== 1'b0)
            $display("FAIL load_vs_step got out=%0d term=%0b expected out=4 term=0", dq[0], dt[0]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            ld  = ($urandom_range(0, 15) == 0);
            en  = ($urandom_range(0, 3) != 0);
            up  = ($urandom_range(0, 7) != 0) ? up : ~up;
            sat = ($urandom_range(0, 19) == 0) ? ~sat : sat;
            lv  = 4'($urandom_range(0, 15));
            cyc();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (dq[k] !== 4'(m_c[k]) || dt[k] !== m_t[k])
                    $display("FAIL random[%0d] cycle %0d got out=%0d term=%0b expected out=%0d term=%0b",
                             k, i, dq[k], dt[k], m_c[k], m_t[k]);
                else pass_cnt++;
            end
        end
        rst = 0; ld = 0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_down();
        test_load_clamp();
        test_prescale();
        test_reset_mid();
        test_load_vs_step();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised successor to the lab counter. Adds up/down direction, a programmable modulo limit, wrap or saturate mode, parallel load, a clock-enable prescaler and a one-cycle terminal-count pulse.
- Used as a timebase and event counter in the lab designs, for example as a trigger-condition counter or a cycle timer.
- Counter width comes from NBITS_COUNTER, which is defined in the shared parameters file.

Parameters:
- NBITS_COUNTER, 8, width of the count value and of Output/LoadValue.
- MAX_VALUE, 2**NBITS_COUNTER-1, highest count value; the count range is 0..MAX_VALUE inclusive; must be >= 1.
- PRESCALE, 1, number of enabled cycles per count step; must be >= 1; 1 means a step on every enabled cycle.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Enable  input  1  count enable; advances the prescaler and the count.
- Up  input  1  direction: 1 counts up, 0 counts down; sampled on every step.
- Saturate  input  1  boundary mode: 0 wraps, 1 holds at the boundary; sampled on every step.
- Load  input  1  synchronous parallel load.
- LoadValue  input  NBITS_COUNTER  value captured on Load.
- Output  output  NBITS_COUNTER  current count, registered.
- Terminal  output  1  registered one-cycle pulse on a boundary step.

Behaviour:
- Reset and clocking: one clock domain. Reset is synchronous and active-high, sampled on the rising edge of Clock.
- Reset values: Output=0, Terminal=0, internal prescaler count=0.
- Priority per edge: Reset > Load > Enable step > hold.
- Load:
  - Output <= min(LoadValue, MAX_VALUE); values above MAX_VALUE are clamped.
  - Prescaler <= 0 and Terminal <= 0.
  - Enable is ignored in that cycle.
- Prescaler, while Enable=1 and there is no Load/Reset:
  - if prescaler == PRESCALE-1, then prescaler <= 0 and a step occurs in this cycle;
  - otherwise prescaler increments and no step occurs.
- Enable=0: the prescaler and Output hold, and Terminal <= 0.
- Step, Up=1:
  - Output < MAX_VALUE: Output <= Output+1.
  - Output == MAX_VALUE: Output <= 0 if Saturate=0, otherwise it holds at MAX_VALUE.
- Step, Up=0:
  - Output > 0: Output <= Output-1.
  - Output == 0: Output <= MAX_VALUE if Saturate=0, otherwise it holds at 0.
- Terminal:
  - Terminal <= 1 on any step taken while Output sits at the boundary in the current direction (MAX_VALUE when up, 0 when down), in either mode.
  - Otherwise Terminal <= 0.
  - It is therefore high for exactly the one cycle after the boundary step. In saturate mode, repeated steps at the boundary give Terminal high on each step cycle's following cycle.
- Up and Saturate are sampled only on steps, so changing them between steps has no effect until the next step. A direction change takes effect on the very next step, with no extra latency.
- Latency: a step appears on Output on the same edge that completes the PRESCALE-th enabled cycle, i.e. Output updates 1 edge after the final enabling cycle is sampled.
- Reset mid-prescale: the prescaler clears and the first step after release again needs PRESCALE enabled cycles.
- Load in the same cycle as a boundary step: Load wins and Terminal=0.
- Values of Output above MAX_VALUE are unreachable, so no special handling is required.
- Arithmetic is unsigned at NBITS_COUNTER width. When MAX_VALUE = 2**NBITS_COUNTER-1, natural overflow must match the wrap rule.

Test Plan:
1. NBITS_COUNTER=4, MAX_VALUE=9, PRESCALE=1; Reset then Enable=1, Up=1, Saturate=0 for 12 cycles -> Output goes 1..9,0,1,2; Terminal high only in the cycle where Output first reads 0.
2. Same config; Up=0, Saturate=0 from Output=0 -> Output goes 9,8,7; Terminal high in the cycle Output=9. Then Saturate=1 from Output=0 -> Output stays 0 and Terminal pulses high on every step while held at 0.
3. Saturate=1, Up=1, Load with LoadValue=15 (clamped to 9) -> Output=9 and Terminal=0; the next step leaves Output=9 with Terminal=1.
4. PRESCALE=3, Enable=1 -> Output increments every 3rd cycle. Drop Enable for 2 cycles after the first prescaler tick: Output and prescaler hold, and the step lands 2 cycles later than it otherwise would.
5. Assert Reset during counting at Output=6 with the prescaler at 1 -> Output=0, Terminal=0 on the next edge; the first step after release needs 3 enabled cycles.
6. Load=1 and Enable=1 on the same edge with Output=9, Up=1 -> Output=LoadValue (e.g. 4) and Terminal=0, with no wrap.
